serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one instance of the team's existing 1-bit full adder, `fulladder1b`.
- Processes one bit pair per clock, LSB first, and keeps the carry in a flip-flop between bits.
- Sits directly downstream of operand sources and feeds `fulladder1b` its serial a/b/cin stream.
- Gives an area-minimal multi-bit add with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request to begin an add; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- sum  output  WIDTH  registered result; holds the last completed sum.
- cout  output  1  registered carry-out of the last completed add.
- busy  output  1  high while an add is in progress (SHIFT state).
- done  output  1  one-cycle pulse, high in the cycle the result becomes valid.

Behaviour:
- Reset, while rst=1 at a rising edge:
  - state=IDLE.
  - sum=0, cout=0, busy=0, done=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset applied mid-operation aborts the add; no done pulse for it.
  - rst has priority over start.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge loads a_sh=a, b_sh=b, carry=cin, cnt=0, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT:
  - busy=1.
  - Each edge feeds a_sh[0], b_sh[0] and carry into `fulladder1b`.
  - The fulladder `s` output is shifted into the MSB of an internal result register, which shifts right.
  - a_sh and b_sh shift right; carry takes the fulladder `cout`; cnt increments.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th bit): sum is loaded with the complete result, cout with the final carry, and the state moves to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: with start sampled at edge k, done is high between edge k+WIDTH and edge k+WIDTH+1. For WIDTH=8 that is 8 edges after acceptance.
- Back-to-back throughput: one add per WIDTH+2 cycles.
- start in SHIFT or DONE is ignored. It is not queued, and operands are not re-captured.
- a, b and cin may change freely after the accepting edge without affecting the result in flight.
- sum and cout change only on the completing edge (or reset). They hold their value through the next operation until its completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width is $clog2(WIDTH)+1 bits, so WIDTH=1 is legal. In that case SHIFT lasts one cycle.
- X on start in IDLE is a bench error; the design is not required to tolerate it.

Test Plan:
1. WIDTH=8, rst high 2 cycles, then start=1 for one cycle with a=8'h5A, b=8'h33, cin=0 -> busy high 8 cycles; done pulses exactly 8 edges after acceptance; sum=8'h8D, cout=0; done low again next cycle.
2. WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Prior sum is held until the second done.
3. Start while busy: accept a=8'h10, b=8'h20, cin=0; at SHIFT cycle 3 pulse start with a=8'hFF, b=8'hFF and change the a/b pins -> single done; sum=8'h30, cout=0; no second operation begins.
4. Reset mid-operation: accept a=8'hAA, b=8'h55, cin=1; assert rst at SHIFT cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse appears within 12 cycles after rst deasserts without a new start.
5. WIDTH=1 instance, all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1). done follows each acceptance by 1 edge.
6. Back-to-back: hold start=1 continuously with random operands (1000 adds, WIDTH=8) -> new add accepted on each IDLE cycle, one per 10 cycles; every done result equals a+b+cin captured at its acceptance edge.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder1b evaluates one bit pair per clock, LSB first,
// with the carry held in a flop between bits and a start/busy/done handshake around it.

module fulladder1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  // One extra counter bit keeps WIDTH=1 legal (a zero-width counter would not be).
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_cout;

  fulladder1b u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= res_next;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Final bit: publish the complete result together with the last carry.
            sum   <= res_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed tables for WIDTH=8 and WIDTH=1, handshake
// corner cases, and a back-to-back random run against an arithmetic reference model.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cin;
  logic [7:0] a, b, sum;
  logic       cout, busy, done;

  logic start1, a1, b1, cin1, sum1, cout1, busy1, done1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;   // {cout, sum}
  } vec8_t;

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] exp;   // {cout, sum}
  } vec1_t;

  int checks   = 0;
  int failures = 0;

  logic [8:0] last_res;  // last completed {cout,sum} the bench expects the DUT to hold

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete WIDTH=8 add with handshake timing and result-hold checks.
  task automatic add8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input logic [8:0] exp, input string name);
    start = 1'b1; a = xa; b = xb; cin = xc;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check({name, " busy"}, 32'(busy), 32'd1);
      check({name, " done_early"}, 32'(done), 32'd0);
      check({name, " hold"}, 32'({cout, sum}), 32'(last_res));
      tick();
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " busy_off"}, 32'(busy), 32'd0);
    check({name, " result"}, 32'({cout, sum}), 32'(exp));
    last_res = exp;
    tick();
    check({name, " done_clear"}, 32'(done), 32'd0);
  endtask

  vec8_t      tab8[8];
  vec1_t      tab1[8];
  logic [8:0] model_q[$];
  logic [8:0] exp_v;

  initial begin
    tab8[0] = '{8'h5A, 8'h33, 1'b0, 9'h08D};
    tab8[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    tab8[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    tab8[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    tab8[4] = '{8'h00, 8'h00, 1'b1, 9'h001};
    tab8[5] = '{8'h80, 8'h80, 1'b0, 9'h100};
    tab8[6] = '{8'h7F, 8'h01, 1'b0, 9'h080};
    tab8[7] = '{8'hA5, 8'h5A, 1'b1, 9'h100};

    tab1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tab1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    tab1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tab1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tab1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    tab1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tab1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    tab1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'({cout, sum}), 32'd0);
    check("reset w1 busy", 32'(busy1), 32'd0);
    check("reset w1 result", 32'({cout1, sum1, done1}), 32'd0);
    last_res = '0;

    // Directed WIDTH=8 vectors; consecutive entries also check the held prior result.
    for (int i = 0; i < 8; i++)
      add8(tab8[i].a, tab8[i].b, tab8[i].cin, tab8[i].exp, $sformatf("vec8[%0d]", i));

    // start while busy must be ignored and not re-capture operands.
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 3; i < 8; i++) begin
      check("busy_start done_early", 32'(done), 32'd0);
      tick();
    end
    check("busy_start done", 32'(done), 32'd1);
    check("busy_start result", 32'({cout, sum}), 32'h030);
    last_res = 9'h030;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("busy_start no_second", 32'({busy, done}), 32'd0);
    end

    // WIDTH=1 truth table: done one edge after acceptance.
    for (int i = 0; i < 8; i++) begin
      start1 = 1'b1; a1 = tab1[i].a; b1 = tab1[i].b; cin1 = tab1[i].cin;
      tick();
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      check($sformatf("vec1[%0d] busy", i), 32'({busy1, done1}), 32'b10);
      tick();
      check($sformatf("vec1[%0d] done", i), 32'({busy1, done1}), 32'b01);
      check($sformatf("vec1[%0d] result", i), 32'({cout1, sum1}), 32'(tab1[i].exp));
      tick();
      check($sformatf("vec1[%0d] done_clear", i), 32'(done1), 32'd0);
    end

    // Reset in the middle of an add aborts it.
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", 32'({cout, sum}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("midrst no_done", 32'({busy, done}), 32'd0);
    end
    last_res = '0;

    // Back-to-back with start held high: an add is accepted every 10 cycles.
    start = 1'b1;
    for (int t = 0; t < 10000; t++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      if (t % 10 == 0) model_q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
      tick();
      check("b2b done", 32'(done), 32'((t % 10) == 8));
      if ((t % 10) == 8 && model_q.size() > 0) begin
        exp_v = model_q.pop_front();
        check("b2b result", 32'({cout, sum}), 32'(exp_v));
      end
    end
    start = 1'b0;
    check("b2b drained", 32'(model_q.size()), 32'd0);
    tick();
    tick();
    check("b2b idle", 32'({busy, done}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
